alu_issue_arbiter: RTL
======================

// Module: alu_issue_arbiter
// PURPOSE
//  Shares one gbprocessor ALU between NUM_REQ requesters (test agents, microcode units).
//  Picks one request round-robin and drives instruction/data_in/valid into the ALU.
//  Waits RESULT_LAT cycles, samples probe, and returns the result tagged with the requester id.
//  A requester can lock the ALU across a multi-op sequence, since accumulator/flag state is shared.
// PARAMETERS
//  NUM_REQ      4   number of requesters, 2..8
//  INSTR_W      8   instruction width
//  DATA_W       8   operand / probe width
//  RESULT_LAT   2   cycles from the alu_valid cycle until probe is valid, >=1
//  LOCK_TMO     16  idle cycles before a held lock is force-released, >=1
// PORTS
//  clock        in   1                  single clock, rising edge
//  reset        in   1                  asynchronous, active-low
//  req_valid    in   NUM_REQ            per-requester request
//  req_ready    out  NUM_REQ            one-hot grant; accept = valid&ready
//  req_instr    in   NUM_REQ*INSTR_W    packed; slice i belongs to requester i
//  req_data     in   NUM_REQ*DATA_W     packed operands
//  req_last     in   NUM_REQ            1 = release the lock after this op
//  alu_instr    out  INSTR_W            to gbprocessor.instruction
//  alu_data     out  DATA_W             to gbprocessor.data_in
//  alu_valid    out  1                  to gbprocessor.valid
//  alu_probe    in   DATA_W             from gbprocessor.probe
//  rsp_valid    out  1                  1-cycle result strobe
//  rsp_id       out  $clog2(NUM_REQ)    requester that owns the result
//  rsp_result   out  DATA_W             sampled probe
//  busy         out  1                  1 when FSM != IDLE
//  lock_owner   out  NUM_REQ            one-hot lock holder; 0 = unlocked
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - FSM=IDLE; RR pointer=0; lock cleared; timeout counter=0.
//   - All outputs 0. An in-flight op is dropped and no rsp is produced.
//  FSM states IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE:
//   - Eligible set = req_valid, or req_valid & lock_owner when locked.
//   - req_ready is combinational: one-hot first eligible index at or after the RR pointer, wrapping.
//   - req_ready is all-zero outside IDLE.
//   - On accept: latch instr/data/id/last, RR pointer = winner+1 mod NUM_REQ, go to ISSUE.
//   - If req_last=0: lock_owner=winner. If req_last=1: lock cleared.
//  ISSUE: alu_valid=1 for exactly 1 cycle, with latched alu_instr/alu_data. Go to WAIT.
//   - alu_instr/alu_data hold their values until the next accept; they are 0 after reset.
//  WAIT: lasts RESULT_LAT cycles; probe is registered on the edge ending the last WAIT cycle.
//  RESP: rsp_valid=1 for 1 cycle with rsp_id/rsp_result; no backpressure. Go to IDLE.
//  Latency: accept in cycle T -> rsp_valid in cycle T+RESULT_LAT+2.
//   - Max throughput is one op per RESULT_LAT+3 cycles.
//  Lock:
//   - While locked, non-owners get no ready, even if the owner is not requesting.
//   - The timeout counter counts IDLE cycles without an owner accept.
//   - At LOCK_TMO the lock clears and arbitration resumes in the same cycle.
//   - The counter resets on any accept.
//  Boundaries:
//   - All req_valid=0: stay IDLE, pointer unchanged.
//   - Pointer at NUM_REQ-1 wraps to 0.
//   - A req_valid drop outside IDLE has no effect, because requests are latched only at accept.
// TESTING
//  1. Reset mid-WAIT: req0 add accepted, reset low 1 cycle.
//     -> no rsp_valid; all outputs 0; next accept issues cleanly.
//  2. Single op: req2 instr=0x80, data=0x05, last=1, probe=0x2A.
//     -> alu_valid at T+1, rsp_valid at T+4, rsp_id=2, rsp_result=0x2A.
//  3. All 4 req_valid held high, last=1.
//     -> grant order 0,1,2,3,0; one grant every 5 cycles.
//  4. Lock: req1 op with last=0, then req0 and req3 valid.
//     -> only req1 is granted until req1 sends last=1; then req2 pointer gives req3 next.
//  5. Lock timeout: req1 locks, then goes idle 16 cycles with req0 valid.
//     -> lock_owner=0 at cycle 16; req0 granted the same cycle.
//  6. Back-to-back ops: req0 sends ADD data=3 then SUB data=1.
//     -> rsp_result sequence follows probe; busy stays 0 only during IDLE cycles.

Source files
------------

// File: rtl/alu_issue_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_issue_arbiter_if
// Bundles everything between the requesters, the shared gbprocessor ALU and
// the arbiter. The slave modport is the arbiter's view; the master modport is
// the view of whatever drives requests and the ALU probe (agents / bench).
//
// Signals
//   req_valid  [NUM_REQ]           per-requester request
//   req_ready  [NUM_REQ]           one-hot grant, accept = valid & ready
//   req_instr  [NUM_REQ*INSTR_W]   packed instruction, slice i = requester i
//   req_data   [NUM_REQ*DATA_W]    packed operand
//   req_last   [NUM_REQ]           1 = release the lock after this op
//   alu_instr / alu_data / alu_valid   issue port into the ALU
//   alu_probe  [DATA_W]            result read back from the ALU
//   rsp_valid / rsp_id / rsp_result    one-cycle tagged result strobe
//   busy                           arbiter is not idle
//   lock_owner [NUM_REQ]           one-hot lock holder, 0 = unlocked
// ----------------------------------------------------------------------------
interface alu_issue_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int INSTR_W = 8,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*INSTR_W-1:0] req_instr;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_last;
    logic [INSTR_W-1:0]         alu_instr;
    logic [DATA_W-1:0]          alu_data;
    logic                       alu_valid;
    logic [DATA_W-1:0]          alu_probe;
    logic                       rsp_valid;
    logic [ID_W-1:0]            rsp_id;
    logic [DATA_W-1:0]          rsp_result;
    logic                       busy;
    logic [NUM_REQ-1:0]         lock_owner;

    modport master (
        output req_valid, req_instr, req_data, req_last, alu_probe,
        input  req_ready, alu_instr, alu_data, alu_valid,
               rsp_valid, rsp_id, rsp_result, busy, lock_owner
    );

    modport slave (
        input  req_valid, req_instr, req_data, req_last, alu_probe,
        output req_ready, alu_instr, alu_data, alu_valid,
               rsp_valid, rsp_id, rsp_result, busy, lock_owner
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// ----------------------------------------------------------------------------
// alu_issue_arbiter
// Shares one gbprocessor ALU between NUM_REQ requesters. A round-robin pick is
// made in IDLE, the latched op is issued for one cycle, the ALU probe is
// sampled RESULT_LAT cycles after issue and returned tagged with the
// requester id. A requester may hold a lock across several ops because the
// accumulator/flags inside the ALU are shared; an idle lock is force-released
// after LOCK_TMO idle cycles.
//
// Ports
//   clock  rising-edge clock
//   reset  asynchronous, active-low
//   bus    alu_issue_arbiter_if.slave (requests, ALU issue/probe, responses,
//          busy, lock_owner)
// ----------------------------------------------------------------------------
module alu_issue_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int INSTR_W    = 8,
    parameter int DATA_W     = 8,
    parameter int RESULT_LAT = 2,
    parameter int LOCK_TMO   = 16
) (
    input  logic               clock,
    input  logic               reset,
    alu_issue_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WC_W = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
    localparam int TC_W = $clog2(LOCK_TMO + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_reg, state_next;
    logic [ID_W-1:0]     ptr_reg, ptr_next;
    logic [NUM_REQ-1:0]  lock_reg, lock_next;
    logic [TC_W-1:0]     tmo_reg, tmo_next;
    logic [WC_W-1:0]     wcnt_reg, wcnt_next;
    logic [INSTR_W-1:0]  instr_reg, instr_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic [DATA_W-1:0]   result_reg, result_next;
    logic [ID_W-1:0]     id_reg, id_next;

    logic [INSTR_W-1:0]  instr_arr [NUM_REQ];
    logic [DATA_W-1:0]   data_arr  [NUM_REQ];

    logic                lock_expired;
    logic [NUM_REQ-1:0]  lock_eff;
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     winner;
    logic [ID_W:0]       idx;
    logic                found;
    logic                accept;
    logic                wait_done;

    // Unpack the per-requester slices once so the datapath can index them.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign instr_arr[gi] = bus.req_instr[gi*INSTR_W +: INSTR_W];
            assign data_arr[gi]  = bus.req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Once the idle counter reaches LOCK_TMO the lock is treated as gone in
    // the same cycle, so arbitration can pick a new winner immediately.
    assign lock_expired = (lock_reg != '0) && (tmo_reg == TC_W'(LOCK_TMO));
    assign lock_eff     = lock_expired ? '0 : lock_reg;
    assign elig         = bus.req_valid & ((lock_eff != '0) ? lock_eff : '1);
    assign wait_done    = (wcnt_reg == WC_W'(RESULT_LAT - 1));

    // Round-robin search starting at the pointer, wrapping past NUM_REQ-1.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_reg} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!found && elig[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    assign accept = (state_reg == IDLE) && found;
    assign grant  = accept ? (NUM_REQ'(1) << winner) : '0;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (wait_done) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values: latch on accept, lock bookkeeping, wait count,
    // probe capture on the edge ending the last WAIT cycle.
    always_comb begin
        ptr_next    = ptr_reg;
        lock_next   = lock_reg;
        tmo_next    = tmo_reg;
        wcnt_next   = wcnt_reg;
        instr_next  = instr_reg;
        data_next   = data_reg;
        id_next     = id_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    instr_next = instr_arr[winner];
                    data_next  = data_arr[winner];
                    id_next    = winner;
                    ptr_next   = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
                    lock_next  = bus.req_last[winner] ? '0 : grant;
                    tmo_next   = '0;
                end else if (lock_expired) begin
                    lock_next = '0;
                    tmo_next  = '0;
                end else if (lock_reg != '0) begin
                    tmo_next = tmo_reg + TC_W'(1);
                end
            end
            ISSUE: wcnt_next = '0;
            WAIT: begin
                wcnt_next = wcnt_reg + WC_W'(1);
                if (wait_done) begin
                    result_next = bus.alu_probe;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_reg    <= '0;
            lock_reg   <= '0;
            tmo_reg    <= '0;
            wcnt_reg   <= '0;
            instr_reg  <= '0;
            data_reg   <= '0;
            id_reg     <= '0;
            result_reg <= '0;
        end else begin
            ptr_reg    <= ptr_next;
            lock_reg   <= lock_next;
            tmo_reg    <= tmo_next;
            wcnt_reg   <= wcnt_next;
            instr_reg  <= instr_next;
            data_reg   <= data_next;
            id_reg     <= id_next;
            result_reg <= result_next;
        end
    end

    // Outputs
    always_comb begin
        bus.req_ready  = grant;
        bus.alu_valid  = (state_reg == ISSUE);
        bus.alu_instr  = instr_reg;
        bus.alu_data   = data_reg;
        bus.rsp_valid  = (state_reg == RESP);
        bus.rsp_id     = id_reg;
        bus.rsp_result = result_reg;
        bus.busy       = (state_reg != IDLE);
        bus.lock_owner = lock_eff;
    end
endmodule
